cnn_frame_loader: RTL

- Upstream feeder for the CNN top-level pipeline (conv -> pool -> FC -> ReLU).
- Accepts one 8x8 image as a valid/ready pixel stream and stores it in a local frame buffer.
- Presents the frame as a parallel image bus to the CNN and holds its enable until the CNN reports done.
- Captures the CNN result, then rearms for the next frame; adds frame-framing error and timeout detection.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_frame_buf.sv | 32 +++
 rtl/cnn_frame_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame loader slice.
//   IMG_W / IMG_H / DATA_W : image geometry and pixel/result width
//   N_PIX / ADDR_W         : pixel count per frame and frame-buffer address width
//   pixel_t                : signed pixel / result word
//   loader_state_e         : frame loader FSM states
package cnn_pkg;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int DATA_W = 32;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(N_PIX);

  typedef logic signed [DATA_W-1:0] pixel_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } loader_state_e;
endpackage

// File: rtl/cnn_frame_buf.sv
// Frame buffer: N_PIX words of DATA_W bits with one write port and the whole
// array exposed as a flattened parallel read bus.
//   clk, rst_n : clock, asynchronous active-low clear of every word
//   we, addr   : write enable and word address
//   data       : write data
//   rd_bus     : word k at bits [k*DATA_W +: DATA_W]
module cnn_frame_buf
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  pixel_t                  data,
  output logic [N_PIX*DATA_W-1:0] rd_bus
);

  pixel_t mem [N_PIX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIX; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= data;
    end
  end

  for (genvar k = 0; k < N_PIX; k++) begin : g_rd
    assign rd_bus[k*DATA_W +: DATA_W] = mem[k];
  end

endmodule

// File: rtl/cnn_frame_loader.sv
// Upstream feeder for the CNN pipeline. Collects one IMG_W x IMG_H frame from a
// valid/ready pixel stream, presents it on img_out, holds cnn_enable until the
// CNN reports done (or a timeout expires), captures the result and rearms.
//
// Handshake: a pixel transfers on every rising clk edge where s_valid and
// s_ready are both 1; s_ready is high exactly while the loader is in LOAD, and
// the producer must hold s_data/s_last stable while s_valid is high and
// s_ready is low.
//
//   s_valid/s_ready/s_data/s_last : pixel stream, raster order
//   img_out                       : frame buffer, pixel k at [k*DATA_W +: DATA_W]
//   cnn_enable / cnn_done / cnn_value : CNN start/hold, completion, result
//   result / result_valid         : captured result and its one-cycle pulse
//   frame_err / timeout           : one-cycle error pulses
//   frames_done                   : wrapping count of completed frames
//   state_dbg                     : current FSM state, for observation
module cnn_frame_loader
  import cnn_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  output logic [N_PIX*DATA_W-1:0] img_out,
  output logic                    cnn_enable,
  input  logic                    cnn_done,
  input  logic [DATA_W-1:0]       cnn_value,
  output logic [DATA_W-1:0]       result,
  output logic                    result_valid,
  output logic                    frame_err,
  output logic                    timeout,
  output logic [CNT_W-1:0]        frames_done,
  output loader_state_e           state_dbg
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(N_PIX - 1);

  loader_state_e     state, state_d;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_d;
  logic              en_d, rv_d, ferr_d, to_d;
  logic [DATA_W-1:0] result_d;
  logic [CNT_W-1:0]  frames_d;
  logic              hs;

  assign s_ready   = (state == ST_LOAD);
  assign hs        = s_valid & s_ready;
  assign state_dbg = state;

  cnn_frame_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (hs),
    .addr   (wr_ptr),
    .data   (pixel_t'(s_data)),
    .rd_bus (img_out)
  );

  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    tmo_d    = tmo_cnt;
    en_d     = cnn_enable;
    result_d = result;
    frames_d = frames_done;
    rv_d     = 1'b0;
    ferr_d   = 1'b0;
    to_d     = 1'b0;
    case (state)
      ST_LOAD: begin
        if (hs) begin
          if (wr_ptr == PTR_LAST) begin
            // Full frame: launch even when s_last is missing, flagging it.
            state_d  = ST_RUN;
            en_d     = 1'b1;
            wr_ptr_d = '0;
            tmo_d    = '0;
            ferr_d   = ~s_last;
          end else if (s_last) begin
            // Short frame: drop it; stale words get overwritten next frame.
            ferr_d   = 1'b1;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (cnn_done) begin
          result_d = cnn_value;
          rv_d     = 1'b1;
          frames_d = frames_done + CNT_W'(1);
          en_d     = 1'b0;
          state_d  = ST_LOAD;
          tmo_d    = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          to_d    = 1'b1;
          en_d    = 1'b0;
          state_d = ST_LOAD;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LOAD;
      wr_ptr       <= '0;
      tmo_cnt      <= '0;
      cnn_enable   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      timeout      <= 1'b0;
      frames_done  <= '0;
    end else begin
      state        <= state_d;
      wr_ptr       <= wr_ptr_d;
      tmo_cnt      <= tmo_d;
      cnn_enable   <= en_d;
      result       <= result_d;
      result_valid <= rv_d;
      frame_err    <= ferr_d;
      timeout      <= to_d;
      frames_done  <= frames_d;
    end
  end

endmodule
